// File: rtl/apb_reg_bridge.sv
// ---------------------------------------------------------------------------
// apb_reg_bridge
//
// APB3 slave front-end for the sample register block. It turns an APB
// setup/access handshake into held select/write/addr/wdata strobes toward the
// register block. It samples the block's combinational read data at the end of
// the access window and returns a one-cycle pready with prdata/pslverr.
//
// Illegal accesses are decoded here and never reach the register block.
// An access is illegal when it is unaligned, above MAX_ADDR, or a write at or
// above RO_BASE.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous reset, active-high
//   i_psel         APB select
//   i_penable      APB enable (access phase)
//   i_pwrite       APB direction, 1 = write
//   i_paddr        APB address
//   i_pwdata       APB write data
//   o_prdata       APB read data, valid with o_pready on a read
//   o_pready       APB completion, single-cycle pulse
//   o_pslverr      APB error, valid with o_pready
//   o_reg_select   register block select
//   o_reg_write    register block write strobe
//   o_reg_addr     register block address
//   o_reg_wdata    register block write data
//   i_reg_rdata    register block combinational read data
// ---------------------------------------------------------------------------
module apb_reg_bridge #(
  parameter int unsigned              ADDR_W      = 8,
  parameter int unsigned              DATA_W      = 8,
  parameter int unsigned              WAIT_CYCLES = 1,
  parameter int unsigned              ADDR_STRIDE = 8,
  parameter logic [ADDR_W-1:0]        MAX_ADDR    = 'h48,
  parameter logic [ADDR_W-1:0]        RO_BASE     = 'h40
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic              i_pwrite,
  input  logic [ADDR_W-1:0] i_paddr,
  input  logic [DATA_W-1:0] i_pwdata,
  output logic [DATA_W-1:0] o_prdata,
  output logic              o_pready,
  output logic              o_pslverr,
  output logic              o_reg_select,
  output logic              o_reg_write,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [DATA_W-1:0] o_reg_wdata,
  input  logic [DATA_W-1:0] i_reg_rdata
);

  // state  | meaning
  // IDLE   | waiting for an APB setup phase (psel=1, penable=0)
  // ACCESS | strobes held toward the register block, wait counter running
  // RESP   | pready pulse with captured prdata / pslverr
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] STRIDE_V = ADDR_W'(ADDR_STRIDE);
  localparam logic [3:0]        WAIT_V   = 4'(WAIT_CYCLES);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_setup;
  logic              w_abort;
  logic              w_done;
  logic              w_addr_err;

  logic              w_select_nxt;
  logic              w_write_nxt;
  logic              w_pready_nxt;
  logic              w_pslverr_nxt;
  logic [DATA_W-1:0] w_prdata_nxt;

  assign w_setup = (r_state == S_IDLE) && i_psel && !i_penable;

  // Dropping penable with psel still high is a protocol violation; it ends
  // the transfer exactly like deselecting.
  assign w_abort = (r_state == S_ACCESS) && !(i_psel && i_penable);
  assign w_done  = (r_state == S_ACCESS) && !w_abort && (r_cnt == 4'd0);

  assign w_addr_err = ((i_paddr % STRIDE_V) != '0) ||
                      (i_paddr > MAX_ADDR) ||
                      (i_pwrite && (i_paddr >= RO_BASE));

  // ------------------------------------------------------------------
  // State register and latched transfer context
  // ------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_setup) begin
        r_addr  <= i_paddr;
        r_wdata <= i_pwdata;
        r_write <= i_pwrite;
        r_err   <= w_addr_err;
        r_cnt   <= WAIT_V;
      end else if ((r_state == S_ACCESS) && !w_abort && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Output logic: values the registered outputs take on the next edge.
  // Strobes are raised on the edge that enters ACCESS so they are valid for
  // every ACCESS cycle, and dropped on the edge that leaves it.
  // ------------------------------------------------------------------
  always_comb begin
    w_select_nxt  = 1'b0;
    w_write_nxt   = 1'b0;
    w_pready_nxt  = 1'b0;
    w_pslverr_nxt = 1'b0;
    w_prdata_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_select_nxt = !w_addr_err;
          w_write_nxt  = !w_addr_err && i_pwrite;
        end
      end
      S_ACCESS: begin
        if (w_done) begin
          w_pready_nxt  = 1'b1;
          w_pslverr_nxt = r_err;
          w_prdata_nxt  = (!r_write && !r_err) ? i_reg_rdata : '0;
        end else if (!w_abort) begin
          w_select_nxt = !r_err;
          w_write_nxt  = !r_err && r_write;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_reg_select <= 1'b0;
      o_reg_write  <= 1'b0;
      o_pready     <= 1'b0;
      o_pslverr    <= 1'b0;
      o_prdata     <= '0;
    end else begin
      o_reg_select <= w_select_nxt;
      o_reg_write  <= w_write_nxt;
      o_pready     <= w_pready_nxt;
      o_pslverr    <= w_pslverr_nxt;
      o_prdata     <= w_prdata_nxt;
    end
  end

  assign o_reg_addr  = r_addr;
  assign o_reg_wdata = r_wdata;

endmodule

// File: tb/tb_apb_reg_bridge.sv
module tb_apb_reg_bridge;

  localparam int WAIT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr, reg_select, reg_write;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_reg_bridge #(.WAIT_CYCLES(WAIT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_psel      (psel),
    .i_penable   (penable),
    .i_pwrite    (pwrite),
    .i_paddr     (paddr),
    .i_pwdata    (pwdata),
    .o_prdata    (prdata),
    .o_pready    (pready),
    .o_pslverr   (pslverr),
    .o_reg_select(reg_select),
    .o_reg_write (reg_write),
    .o_reg_addr  (reg_addr),
    .o_reg_wdata (reg_wdata),
    .i_reg_rdata (reg_rdata)
  );

  // Stand-in for the register block: ten 8-bit registers at stride 8,
  // 0x40/0x48 reset to 0x6E/0x0D. It writes whatever it is told to write,
  // so any leak of an illegal write shows up on a later read.
  logic [7:0] rb_mem [10];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) rb_mem[i] <= 8'h00;
      rb_mem[8] <= 8'h6E;
      rb_mem[9] <= 8'h0D;
    end else if (reg_select && reg_write && reg_addr[2:0] == 3'd0 && reg_addr <= 8'h48) begin
      rb_mem[reg_addr[6:3]] <= reg_wdata;
    end
  end
  always_comb begin
    reg_rdata = 8'h00;
    if (reg_select && reg_addr[2:0] == 3'd0 && reg_addr <= 8'h48)
      reg_rdata = rb_mem[reg_addr[6:3]];
  end

  // Reference model: register contents as an array, transfers as whole
  // transactions.
  logic [7:0] m_mem [10];

  task automatic m_reset();
    for (int i = 0; i < 10; i++) m_mem[i] = 8'h00;
    m_mem[8] = 8'h6E;
    m_mem[9] = 8'h0D;
  endtask

  function automatic bit m_err(bit wr, logic [7:0] a);
    int ai;
    ai = int'(a);
    return (ai % 8 != 0) || (ai > 72) || (wr && ai >= 64);
  endfunction

  task automatic m_apply(input bit wr, input logic [7:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output bit e);
    e  = m_err(wr, a);
    rd = 8'h00;
    if (!e && !wr) rd = m_mem[int'(a) / 8];
    if (!e && wr)  m_mem[int'(a) / 8] = d;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1 of the setup cycle; returns at posedge+1 of the cycle
  // after pready, bus idle, so a following call starts with no bubble.
  task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic e, output int lat,
                      output int nsel, output int nwr, output int nbad, output int pcyc);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    lat = -1; nsel = 0; nwr = 0; nbad = 0; rd = 8'h00; e = 1'b0; pcyc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (reg_select === 1'b1) begin
        nsel++;
        if (reg_addr !== a || (wr && reg_wdata !== d)) nbad++;
      end
      if (reg_write === 1'b1) nwr++;
      if (pready === 1'b1) begin
        lat = k; rd = prdata; e = pslverr; pcyc = cyc;
        break;
      end
      @(posedge clk); #1;
      penable = 1'b1;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Runs one transfer and checks it against the model (and, optionally,
  // against hand-written table values).
  task automatic run_check(input string name, input bit wr, input logic [7:0] a,
                           input logic [7:0] d, input bit use_tbl,
                           input logic [7:0] t_rd, input bit t_err, output int pcyc);
    logic [7:0] rd, m_rd;
    logic       e;
    bit         m_e;
    int         lat, nsel, nwr, nbad;
    m_apply(wr, a, d, m_rd, m_e);
    xfer(wr, a, d, rd, e, lat, nsel, nwr, nbad, pcyc);
    if (use_tbl) begin
      chk({name, ".rdata"}, {24'h0, rd}, {24'h0, t_rd});
      chk({name, ".pslverr"}, {31'h0, e}, {31'h0, t_err});
    end else begin
      chk({name, ".rdata"}, {24'h0, rd}, {24'h0, m_rd});
      chk({name, ".pslverr"}, {31'h0, e}, {31'h0, m_e});
    end
    chk({name, ".latency"}, lat, WAIT + 2);
    chk({name, ".sel_cycles"}, nsel, m_e ? 0 : WAIT + 1);
    chk({name, ".wr_cycles"}, nwr, (!m_e && wr) ? WAIT + 1 : 0);
    chk({name, ".strobe_addr"}, nbad, 0);
  endtask

  // Watches n cycles after an abort/reset: no pready and no select allowed.
  task automatic watch_quiet(input string name, input int n);
    int np, ns;
    np = 0; ns = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (pready !== 1'b0) np++;
      if (reg_select !== 1'b0 || reg_write !== 1'b0) ns++;
      @(posedge clk); #1;
    end
    chk({name, ".no_pready"}, np, 0);
    chk({name, ".no_select"}, ns, 0);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] rd;
    bit         err;
    string      name;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int pc0, pc1, pc;
    tbl[0] = '{1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, "wr_10"};
    tbl[1] = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, "rd_10"};
    tbl[2] = '{1'b0, 8'h40, 8'h00, 8'h6E, 1'b0, "rd_40"};
    tbl[3] = '{1'b0, 8'h48, 8'h00, 8'h0D, 1'b0, "rd_48"};
    tbl[4] = '{1'b1, 8'h40, 8'hFF, 8'h00, 1'b1, "wr_ro_40"};
    tbl[5] = '{1'b0, 8'h40, 8'h00, 8'h6E, 1'b0, "rd_40_again"};
    tbl[6] = '{1'b0, 8'h0C, 8'h00, 8'h00, 1'b1, "rd_unaligned"};
    tbl[7] = '{1'b0, 8'h50, 8'h00, 8'h00, 1'b1, "rd_range"};

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    m_reset();

    // Reset held two clocks with psel toggling.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      psel = ~psel; paddr = 8'h08;
      @(negedge clk);
      chk("reset_outputs", {4'h0, prdata, pready, pslverr, reg_select, reg_write, reg_addr, reg_wdata}, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      run_check(tbl[i].name, tbl[i].wr, tbl[i].addr, tbl[i].data, 1'b1, tbl[i].rd, tbl[i].err, pc);

    // Abort by deselecting in the first ACCESS cycle.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h10;
    @(posedge clk); #1;
    psel = 1'b0;
    @(posedge clk); #1;
    watch_quiet("abort_psel", 5);

    // Abort by holding penable low during ACCESS.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h48;
    @(posedge clk); #1;
    @(posedge clk); #1;
    psel = 1'b0;
    watch_quiet("abort_penable", 5);

    run_check("rd_after_abort", 1'b0, 8'h10, 8'h00, 1'b1, 8'hA5, 1'b0, pc);

    // Reset pulsed during the ACCESS of a write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 8'h5A;
    @(posedge clk); #1;
    penable = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.select_before", {31'h0, reg_select}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    m_reset();
    @(negedge clk);
    chk("rst_mid.outputs", {4'h0, prdata, pready, pslverr, reg_select, reg_write, reg_addr, reg_wdata}, 32'h0);
    @(posedge clk); #1;
    watch_quiet("rst_mid", 4);

    // Back-to-back reads: pready pulses WAIT+3 cycles apart.
    run_check("b2b_rd_00", 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, pc0);
    run_check("b2b_rd_08", 1'b0, 8'h08, 8'h00, 1'b1, 8'h00, 1'b0, pc1);
    chk("b2b.spacing", pc1 - pc0, WAIT + 3);

    // Randomised traffic against the model.
    for (int i = 0; i < 60; i++) begin
      bit         wr;
      logic [7:0] a;
      int         gap;
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) a = 8'($urandom_range(0, 9) * 8);
      else                           a = 8'($urandom_range(0, 255));
      run_check($sformatf("rand%0d", i), wr, a, 8'($urandom), 1'b0, 8'h00, 1'b0, pc);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end

    // Final sweep: every legal register reads back what the model holds.
    for (int i = 0; i < 10; i++)
      run_check($sformatf("sweep%0d", i), 1'b0, 8'(i * 8), 8'h00, 1'b0, 8'h00, 1'b0, pc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule
